// File: rtl/pong_ball.sv
// pong_ball: once-per-frame ball motion with wall/paddle bounces, plus ball overlay.
// Define BALL_SPEEDUP_EN to speed the ball up on each paddle bounce.
module pong_ball #(
  parameter int          H_ACTIVE     = 800,
  parameter int          V_ACTIVE     = 600,
  parameter int          BALL_SIZE    = 16,
  parameter int          SPEED        = 4,
  parameter int          PAD_L_X      = 32,
  parameter int          PAD_R_X      = 752,
  parameter int          PAD_W        = 16,
  parameter int          PAD_H        = 96,
  parameter int          SERVE_FRAMES = 60,
  parameter logic [11:0] BALL_RGB     = 12'hFFF
) (
  input  logic        pclk,
  input  logic        rst,
  input  logic        game_en,
  input  logic [10:0] hcount_in,
  input  logic [10:0] vcount_in,
  input  logic        hsync_in,
  input  logic        vsync_in,
  input  logic        hblnk_in,
  input  logic        vblnk_in,
  input  logic [11:0] rgb_in,
  input  logic [10:0] pad_l_y,
  input  logic [10:0] pad_r_y,
  output logic [10:0] hcount_out,
  output logic [10:0] vcount_out,
  output logic        hsync_out,
  output logic        vsync_out,
  output logic        hblnk_out,
  output logic        vblnk_out,
  output logic [11:0] rgb_out,
  output logic        miss_l,
  output logic        miss_r,
  output logic [10:0] ball_x,
  output logic [10:0] ball_y
);

  typedef enum logic {SERVE, PLAY} state_t;

  localparam logic [11:0] BS     = 12'(BALL_SIZE);
  localparam logic [11:0] L_EDGE = 12'(PAD_L_X + PAD_W);
  localparam logic [11:0] R_EDGE = 12'(PAD_R_X);
  localparam logic [11:0] PH     = 12'(PAD_H);
  localparam logic [11:0] HA     = 12'(H_ACTIVE);
  localparam logic [11:0] VA     = 12'(V_ACTIVE);
  localparam logic [10:0] Y_MAX  = 11'(V_ACTIVE - BALL_SIZE);
  localparam logic [10:0] X_RCL  = 11'(PAD_R_X - BALL_SIZE);
  localparam logic [10:0] X_C    = 11'((H_ACTIVE - BALL_SIZE) / 2);
  localparam logic [10:0] Y_C    = 11'((V_ACTIVE - BALL_SIZE) / 2);
  localparam logic [6:0]  CNT_I  = 7'(SERVE_FRAMES);

  state_t      state_q, state_d;
  logic [6:0]  cnt_q, cnt_d;
  logic [10:0] bx_q, bx_d, by_q, by_d;
  logic        dx_q, dx_d, dy_q, dy_d;
  logic        ml_q, ml_d, mr_q, mr_d;
  logic [10:0] hc_q, vc_q;
  logic        hs_q, vs_q, hb_q, vb_q;
  logic [11:0] rgb_q, rgb_d;

  logic [11:0] spd;
`ifdef BALL_SPEEDUP_EN
  logic [3:0]  spd_q, spd_d;
  assign spd = {8'd0, spd_q};
`else
  assign spd = 12'(SPEED);
`endif

  logic [11:0] x12, y12, hc12, vc12, pl12, pr12;
  logic        step, in_ball, ovl_l, ovl_r, hit_l, hit_r, out_r;

  assign x12  = {1'b0, bx_q};
  assign y12  = {1'b0, by_q};
  assign hc12 = {1'b0, hcount_in};
  assign vc12 = {1'b0, vcount_in};
  assign pl12 = {1'b0, pad_l_y};
  assign pr12 = {1'b0, pad_r_y};

  // Frame tick: rising edge of vblank, seen against its 1-cycle copy.
  assign step = vblnk_in & ~vb_q & game_en;

  assign in_ball = !hblnk_in && !vblnk_in &&
                   hc12 >= x12 && hc12 < x12 + BS &&
                   vc12 >= y12 && vc12 < y12 + BS;
  assign rgb_d = in_ball ? BALL_RGB : rgb_in;

  assign ovl_l = (y12 + BS > pl12) && (y12 < pl12 + PH);
  assign ovl_r = (y12 + BS > pr12) && (y12 < pr12 + PH);
  // Next-position tests rewritten on the current position so nothing wraps.
  assign hit_l = (x12 <= L_EDGE + spd) && (x12 >= L_EDGE) && ovl_l;
  assign hit_r = (x12 + BS + spd >= R_EDGE) && (x12 + BS <= R_EDGE) && ovl_r;
  assign out_r = (x12 + BS + spd) > (HA - spd);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    bx_d    = bx_q;
    by_d    = by_q;
    dx_d    = dx_q;
    dy_d    = dy_q;
    ml_d    = 1'b0;
    mr_d    = 1'b0;
    case (state_q)
      SERVE: begin
        if (step) begin
          if (cnt_q == '0) state_d = PLAY;
          else cnt_d = cnt_q - 7'd1;
        end
      end
      PLAY: begin
        if (step) begin
          unique case (1'b1)
            (!dy_q && y12 < spd): begin
              by_d = '0;
              dy_d = 1'b1;
            end
            (dy_q && y12 + BS + spd > VA): begin
              by_d = Y_MAX;
              dy_d = 1'b0;
            end
            default: by_d = dy_q ? by_q + spd[10:0] : by_q - spd[10:0];
          endcase
          if (!dx_q) begin
            if (hit_l) begin
              bx_d = L_EDGE[10:0];
              dx_d = 1'b1;
            end else if (x12 < {spd[10:0], 1'b0}) begin
              ml_d = 1'b1;
            end else begin
              bx_d = bx_q - spd[10:0];
            end
          end else begin
            if (hit_r) begin
              bx_d = X_RCL;
              dx_d = 1'b0;
            end else if (out_r) begin
              mr_d = 1'b1;
            end else begin
              bx_d = bx_q + spd[10:0];
            end
          end
          // A miss overrides both axes; serve toward the player who missed.
          if (ml_d || mr_d) begin
            state_d = SERVE;
            cnt_d   = CNT_I;
            bx_d    = X_C;
            by_d    = Y_C;
            dx_d    = mr_d;
            dy_d    = dy_q;
          end
        end
      end
      default: state_d = SERVE;
    endcase
  end

`ifdef BALL_SPEEDUP_EN
  always_comb begin
    spd_d = spd_q;
    if (ml_d || mr_d)
      spd_d = 4'(SPEED);
    else if (state_q == PLAY && step && (dx_q ? hit_r : hit_l) && spd_q != 4'hF)
      spd_d = spd_q + 4'd1;
  end

  always_ff @(posedge pclk) begin
    if (rst) spd_q <= 4'(SPEED);
    else     spd_q <= spd_d;
  end
`endif

  always_ff @(posedge pclk) begin
    if (rst) begin
      state_q <= SERVE;
      cnt_q   <= CNT_I;
      bx_q    <= X_C;
      by_q    <= Y_C;
      dx_q    <= 1'b1;
      dy_q    <= 1'b1;
      ml_q    <= 1'b0;
      mr_q    <= 1'b0;
      hc_q    <= '0;
      vc_q    <= '0;
      hs_q    <= 1'b0;
      vs_q    <= 1'b0;
      hb_q    <= 1'b0;
      vb_q    <= 1'b0;
      rgb_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bx_q    <= bx_d;
      by_q    <= by_d;
      dx_q    <= dx_d;
      dy_q    <= dy_d;
      ml_q    <= ml_d;
      mr_q    <= mr_d;
      hc_q    <= hcount_in;
      vc_q    <= vcount_in;
      hs_q    <= hsync_in;
      vs_q    <= vsync_in;
      hb_q    <= hblnk_in;
      vb_q    <= vblnk_in;
      rgb_q   <= rgb_d;
    end
  end

  assign hcount_out = hc_q;
  assign vcount_out = vc_q;
  assign hsync_out  = hs_q;
  assign vsync_out  = vs_q;
  assign hblnk_out  = hb_q;
  assign vblnk_out  = vb_q;
  assign rgb_out    = rgb_q;
  assign miss_l     = ml_q;
  assign miss_r     = mr_q;
  assign ball_x     = bx_q;
  assign ball_y     = by_q;

endmodule

// File: tb/tb_pong_ball.sv
// tb_pong_ball: frame-level ball model checked every cycle, plus pinned literals.
module tb_pong_ball;

  logic        pclk = 1'b0;
  logic        rst, game_en;
  logic [10:0] hcount_in, vcount_in, pad_l_y, pad_r_y;
  logic        hsync_in, vsync_in, hblnk_in, vblnk_in;
  logic [11:0] rgb_in;
  logic [10:0] hcount_out, vcount_out, ball_x, ball_y;
  logic        hsync_out, vsync_out, hblnk_out, vblnk_out;
  logic [11:0] rgb_out;
  logic        miss_l, miss_r;

  pong_ball dut (
    .pclk(pclk), .rst(rst), .game_en(game_en),
    .hcount_in(hcount_in), .vcount_in(vcount_in),
    .hsync_in(hsync_in), .vsync_in(vsync_in),
    .hblnk_in(hblnk_in), .vblnk_in(vblnk_in),
    .rgb_in(rgb_in), .pad_l_y(pad_l_y), .pad_r_y(pad_r_y),
    .hcount_out(hcount_out), .vcount_out(vcount_out),
    .hsync_out(hsync_out), .vsync_out(vsync_out),
    .hblnk_out(hblnk_out), .vblnk_out(vblnk_out),
    .rgb_out(rgb_out), .miss_l(miss_l), .miss_r(miss_r),
    .ball_x(ball_x), .ball_y(ball_y)
  );

  always #5 pclk = ~pclk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", n, a, e);
    end
  endtask

  // Model: ball position/direction in plain integers, directions as +1/-1.
  int  mx, my, mdx, mdy, mcnt, moves;
  bit  mserve, mvq, live;
  int  e_hc, e_vc, e_hs, e_vs, e_hb, e_vb, e_rgb, e_ml, e_mr;
  int  nml = 0, nmr = 0;

  function automatic void step_model();
    int nx, ny, ndx, ndy, pl, pr;
    bit ml, mr;
    if (mserve) begin
      if (mcnt == 0) begin
        mserve = 0;
        moves  = 0;
      end else mcnt--;
      return;
    end
    moves++;
    pl = int'(pad_l_y);
    pr = int'(pad_r_y);
    ny = my + 4 * mdy;
    ndy = mdy;
    if (mdy < 0 && my < 4) begin
      ny = 0; ndy = 1;
    end else if (mdy > 0 && my + 16 + 4 > 600) begin
      ny = 584; ndy = -1;
    end
    nx = mx + 4 * mdx;
    ndx = mdx;
    ml = 0;
    mr = 0;
    if (mdx < 0) begin
      if (nx <= 48 && mx >= 48 && my + 16 > pl && my < pl + 96) begin
        nx = 48; ndx = 1;
      end else if (nx < 4) ml = 1;
    end else begin
      if (nx + 16 >= 752 && mx + 16 <= 752 && my + 16 > pr && my < pr + 96) begin
        nx = 736; ndx = -1;
      end else if (nx + 16 > 796) mr = 1;
    end
    if (ml || mr) begin
      mx = 392; my = 292; mdx = ml ? -1 : 1;
      mserve = 1; mcnt = 60;
      e_ml = int'(ml); e_mr = int'(mr);
    end else begin
      mx = nx; my = ny; mdx = ndx; mdy = ndy;
    end
  endfunction

  always @(posedge pclk) begin
    if (rst) begin
      mx = 392; my = 292; mdx = 1; mdy = 1;
      mserve = 1; mcnt = 60; mvq = 0;
      e_hc = 0; e_vc = 0; e_hs = 0; e_vs = 0;
      e_hb = 0; e_vb = 0; e_rgb = 0; e_ml = 0; e_mr = 0;
    end else begin
      e_hc = int'(hcount_in); e_vc = int'(vcount_in);
      e_hs = int'(hsync_in);  e_vs = int'(vsync_in);
      e_hb = int'(hblnk_in);  e_vb = int'(vblnk_in);
      if (!hblnk_in && !vblnk_in &&
          int'(hcount_in) >= mx && int'(hcount_in) < mx + 16 &&
          int'(vcount_in) >= my && int'(vcount_in) < my + 16)
        e_rgb = 'hFFF;
      else
        e_rgb = int'(rgb_in);
      e_ml = 0; e_mr = 0;
      if (vblnk_in && !mvq && game_en) step_model();
      mvq = vblnk_in;
    end
    live = 1;
  end

  always @(negedge pclk) begin
    if (live) begin
      chk("hcount_out", 32'(hcount_out), e_hc);
      chk("vcount_out", 32'(vcount_out), e_vc);
      chk("syncs", {hsync_out, vsync_out, hblnk_out, vblnk_out},
          32'(e_hs * 8 + e_vs * 4 + e_hb * 2 + e_vb));
      chk("rgb_out", 32'(rgb_out), e_rgb);
      chk("miss_l", 32'(miss_l), e_ml);
      chk("miss_r", 32'(miss_r), e_mr);
      chk("ball_x", 32'(ball_x), mx);
      chk("ball_y", 32'(ball_y), my);
      if (miss_l === 1'b1) nml++;
      if (miss_r === 1'b1) nmr++;
    end
  end

  task automatic cyc();
    @(posedge pclk);
    #1;
  endtask

  task automatic pix(input int h, input int v, input bit hb, input int c);
    hcount_in = 11'(h);
    vcount_in = 11'(v);
    hblnk_in  = hb;
    vblnk_in  = 1'b0;
    hsync_in  = 1'($urandom);
    vsync_in  = 1'($urandom);
    rgb_in    = 12'(c);
    cyc();
  endtask

  function automatic int track(input int y);
    return (y >= 40) ? y - 40 : 0;
  endfunction

  function automatic int away(input int y);
    return (y >= 300) ? 0 : 500;
  endfunction

  // mode 0: both paddles track; 1: left paddle away; 2: right paddle away
  task automatic frame(input int mode);
    pad_l_y = 11'((mode == 1) ? away(my) : track(my));
    pad_r_y = 11'((mode == 2) ? away(my) : track(my));
    pix(mx + int'($urandom_range(15)), my + int'($urandom_range(15)), 0, int'($urandom));
    pix(mx + 16, my, 0, int'($urandom));
    pix(mx, my + 15, 1, int'($urandom));
    pix(int'($urandom_range(799)), int'($urandom_range(599)), 0, int'($urandom));
    hblnk_in = 1'b1;
    vblnk_in = 1'b1;
    hsync_in = 1'b0;
    vsync_in = 1'b1;
    cyc();
    cyc();
  endtask

  task automatic frames(input int n, input int mode);
    repeat (n) frame(mode);
  endtask

  task automatic run_to(input int target, input int mode);
    int n = 0;
    while (moves < target && n < 2000) begin
      frame(mode);
      n++;
    end
    checks++;
    if (moves != target) begin
      errors++;
      $display("FAIL run_to: reached move %0d, required %0d", moves, target);
    end
  endtask

  int b;

  initial begin
    rst = 1'b1; game_en = 1'b1;
    hcount_in = '0; vcount_in = '0; hsync_in = 0; vsync_in = 0;
    hblnk_in = 0; vblnk_in = 0; rgb_in = '0; pad_l_y = '0; pad_r_y = '0;
    cyc();
    cyc();
    chk("reset ball_x", 32'(ball_x), 392);
    chk("reset ball_y", 32'(ball_y), 292);
    chk("reset rgb_out", 32'(rgb_out), 0);
    chk("reset misses", {miss_l, miss_r}, 0);
    rst = 1'b0;

    pix(392, 292, 0, 'h000);
    chk("overlay corner", 32'(rgb_out), 'hFFF);
    pix(408, 292, 0, 'h5A3);
    chk("overlay right edge", 32'(rgb_out), 'h5A3);

    frames(61, 0);
    chk("serve hold x", 32'(ball_x), 392);
    chk("serve hold y", 32'(ball_y), 292);
    frame(0);
    chk("first move x", 32'(ball_x), 396);
    chk("first move y", 32'(ball_y), 296);

    run_to(100, 0);
    game_en = 1'b0;
    frames(10, 0);
    game_en = 1'b1;
    chk("frozen x", 32'(ball_x), 680);
    chk("frozen y", 32'(ball_y), 480);

    run_to(221, 0);
    chk("top clamp y", 32'(ball_y), 0);
    frame(0);
    chk("after top y", 32'(ball_y), 4);

    run_to(258, 0);
    chk("left bounce x", 32'(ball_x), 48);
    run_to(430, 0);
    chk("right bounce x", 32'(ball_x), 736);
    run_to(613, 1);
    chk("near miss x", 32'(ball_x), 4);
    b = nml;
    frame(1);
    chk("miss_l pulses", 32'(nml - b), 1);
    chk("recentre x", 32'(ball_x), 392);
    chk("recentre y", 32'(ball_y), 292);

    frames(61, 0);
    frame(0);
    chk("serve left x", 32'(ball_x), 388);
    run_to(86, 0);
    chk("left bounce 2 x", 32'(ball_x), 48);
    b = nmr;
    run_to(270, 2);
    chk("miss_r pulses", 32'(nmr - b), 1);
    chk("recentre 2 x", 32'(ball_x), 392);
    frames(61, 0);
    frame(0);
    chk("serve right x", 32'(ball_x), 396);

    hcount_in = 11'd123; vcount_in = 11'd45; hsync_in = 1; vsync_in = 1;
    hblnk_in = 1; rgb_in = 12'hABC;
    rst = 1'b1;
    cyc();
    chk("rst hcount_out", 32'(hcount_out), 0);
    chk("rst syncs", {hsync_out, vsync_out, hblnk_out, vblnk_out}, 0);
    chk("rst rgb_out", 32'(rgb_out), 0);
    chk("rst ball_x", 32'(ball_x), 392);
    rst = 1'b0;
    pix(5, 6, 0, 'h123);
    chk("refill hcount_out", 32'(hcount_out), 5);
    chk("refill rgb_out", 32'(rgb_out), 'h123);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

endmodule
